// File: rtl/viterbi_decoder_if.sv
// Symbol-stream bundle between the demodulator (master) and the Viterbi decoder (slave).
// The bundle carries the received symbol, the stream-valid flag and the decoded-bit strobe.
interface viterbi_decoder_if;
  logic [1:0] Rx;
  logic       seqrdy;
  logic       Dx;
  logic       oen;

  modport master (
    output Rx,
    output seqrdy,
    input  Dx,
    input  oen
  );

  modport slave (
    input  Rx,
    input  seqrdy,
    output Dx,
    output oen
  );
endinterface

// File: rtl/viterbi_decoder.sv
// Hard-decision rate-1/2, K=4 Viterbi decoder (g0=1011, g1=1111) with a circular survivor
// memory and a TB_DEPTH-step traceback that emits one decoded bit per symbol once the window fills.
module viterbi_decoder #(
  parameter int TB_DEPTH = 15,
  parameter int PM_W     = 8
) (
  input  logic              clock,
  input  logic              reset,
  viterbi_decoder_if.slave  sym
);

  localparam int PTR_W = $clog2(TB_DEPTH);
  localparam int CNT_W = $clog2(TB_DEPTH + 2);
  localparam logic [PTR_W-1:0] LAST_COL = PTR_W'(TB_DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(TB_DEPTH + 1);
  localparam logic [PM_W-1:0]  PM_INIT  = PM_W'(16);

  typedef enum logic [2:0] {IDLE, BM, ACS, NORM, TRACE, OUT} state_t;

  state_t            state;
  logic [1:0]        bm [8];
  logic [PM_W-1:0]   pm [8];
  logic [7:0]        surv [TB_DEPTH];
  logic [PTR_W-1:0]  write_ptr;
  logic [PTR_W-1:0]  trace_ptr;
  logic [PTR_W-1:0]  trace_cnt;
  logic [CNT_W-1:0]  sym_count;
  logic [2:0]        trace_s;
  logic              dx_q;
  logic              oen_q;

  logic [1:0]        bm_next [8];
  logic [PM_W-1:0]   acs_pm [8];
  logic [7:0]        acs_sel;
  logic [PM_W-1:0]   min_pm;
  logic [2:0]        min_state;

  // bm[p] is the metric of the u=0 branch leaving p; the u=1 branch flips both code bits,
  // so its metric is 2-bm[p] and only 8 metrics need storing.
  for (genvar p = 0; p < 8; p++) begin : g_bm
    localparam logic [2:0] PS = 3'(p);
    localparam logic C0 = PS[1] ^ PS[0];
    localparam logic C1 = PS[2] ^ PS[1] ^ PS[0];
    assign bm_next[p] = {1'b0, sym.Rx[1] ^ C0} + {1'b0, sym.Rx[0] ^ C1};
  end

  for (genvar n = 0; n < 8; n++) begin : g_acs
    localparam logic [2:0] NS = 3'(n);
    localparam logic [2:0] P0 = {NS[1:0], 1'b0};
    localparam logic [2:0] P1 = {NS[1:0], 1'b1};
    localparam logic       U  = NS[2];
    logic [1:0]    bm0;
    logic [1:0]    bm1;
    logic [PM_W:0] m0;
    logic [PM_W:0] m1;
    logic [PM_W:0] best;
    assign bm0  = U ? (2'd2 - bm[P0]) : bm[P0];
    assign bm1  = U ? (2'd2 - bm[P1]) : bm[P1];
    assign m0   = {1'b0, pm[P0]} + {{(PM_W-1){1'b0}}, bm0};
    assign m1   = {1'b0, pm[P1]} + {{(PM_W-1){1'b0}}, bm1};
    assign acs_sel[n] = (m1 < m0);
    assign best = acs_sel[n] ? m1 : m0;
    assign acs_pm[n]  = best[PM_W] ? {PM_W{1'b1}} : best[PM_W-1:0];
  end

  // Linear scan keeps the lowest index on ties, which the traceback start relies on.
  always_comb begin
    min_pm    = pm[0];
    min_state = 3'd0;
    for (int i = 1; i < 8; i++) begin
      if (pm[i] < min_pm) begin
        min_pm    = pm[i];
        min_state = 3'(i);
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      dx_q      <= 1'b0;
      oen_q     <= 1'b0;
      write_ptr <= '0;
      trace_ptr <= '0;
      trace_cnt <= '0;
      trace_s   <= '0;
      sym_count <= '0;
      for (int i = 0; i < 8; i++) begin
        pm[i] <= (i == 0) ? {PM_W{1'b0}} : PM_INIT;
        bm[i] <= 2'd0;
      end
      for (int j = 0; j < TB_DEPTH; j++) begin
        surv[j] <= 8'd0;
      end
    end else begin
      oen_q <= 1'b0;
      case (state)
        IDLE: begin
          if (sym.seqrdy) state <= BM;
        end
        BM: begin
          for (int i = 0; i < 8; i++) bm[i] <= bm_next[i];
          state <= ACS;
        end
        ACS: begin
          for (int i = 0; i < 8; i++) pm[i] <= acs_pm[i];
          surv[write_ptr] <= acs_sel;
          write_ptr <= (write_ptr == LAST_COL) ? '0 : write_ptr + 1'b1;
          if (sym_count != FULL_CNT) sym_count <= sym_count + 1'b1;
          state <= NORM;
        end
        NORM: begin
          for (int i = 0; i < 8; i++) pm[i] <= pm[i] - min_pm;
          if (sym_count == FULL_CNT) begin
            trace_s   <= min_state;
            trace_ptr <= (write_ptr == '0) ? LAST_COL : write_ptr - 1'b1;
            trace_cnt <= '0;
            state     <= TRACE;
          end else begin
            state <= sym.seqrdy ? BM : IDLE;
          end
        end
        // The last step's new s[2] is the current s[1], so Dx is loaded on entry to OUT.
        TRACE: begin
          trace_s   <= {trace_s[1:0], surv[trace_ptr][trace_s]};
          trace_ptr <= (trace_ptr == '0) ? LAST_COL : trace_ptr - 1'b1;
          trace_cnt <= trace_cnt + 1'b1;
          if (trace_cnt == LAST_COL) begin
            dx_q  <= trace_s[1];
            oen_q <= 1'b1;
            state <= OUT;
          end
        end
        OUT: begin
          state <= sym.seqrdy ? BM : IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign sym.Dx  = dx_q;
  assign sym.oen = oen_q;

endmodule

// File: tb/tb_viterbi_decoder.sv
// Bench for viterbi_decoder: random and directed symbol streams scored every cycle against a
// register-exchange Viterbi model with unbounded integer metrics and full path histories.
module tb_viterbi_decoder;

  logic clock = 1'b0;
  logic reset = 1'b1;

  viterbi_decoder_if sym ();

  viterbi_decoder #(.TB_DEPTH(15), .PM_W(8)) dut (
    .clock (clock),
    .reset (reset),
    .sym   (sym)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    int   at;
    logic val;
  } exp_t;

  int   checks   = 0;
  int   failures = 0;
  exp_t exp_q[$];
  logic exp_dx = 1'b0;
  logic got_q[$];
  int   oen_cycles[$];
  int   start_cyc[$];
  logic u_bits[$];
  bit   running = 1'b0;

  int          m_pm [8];
  logic [255:0] m_hist [8];
  int          m_k;

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] required);
    checks++;
    if (actual !== required) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, required, cyc);
    end
  endtask

  function automatic logic [1:0] encode(input logic [2:0] s, input logic u);
    logic [3:0] w;
    w = {u, s};
    return {^(w & 4'b1011), ^(w & 4'b1111)};
  endfunction

  task automatic model_reset();
    for (int n = 0; n < 8; n++) begin
      m_pm[n]   = (n == 0) ? 0 : 16;
      m_hist[n] = '0;
    end
    m_k = 0;
  endtask

  // Every (state, input) transition is tried in ascending state order; a strict '<' keeps the
  // even predecessor on ties. Output is bit k-15 of the best path's full history.
  task automatic model_step(input logic [1:0] rx, output logic has_out, output logic obit);
    int           npm [8];
    logic [255:0] nh [8];
    logic [2:0]   ps;
    logic [2:0]   ns;
    logic         u;
    int           cand;
    int           best;
    for (int n = 0; n < 8; n++) begin
      npm[n] = 1 << 30;
      nh[n]  = '0;
    end
    for (int p = 0; p < 8; p++) begin
      for (int ui = 0; ui < 2; ui++) begin
        ps   = 3'(p);
        u    = 1'(ui);
        ns   = {u, ps[2:1]};
        cand = m_pm[p] + $countones(rx ^ encode(ps, u));
        if (cand < npm[ns]) begin
          npm[ns]     = cand;
          nh[ns]      = m_hist[p];
          nh[ns][m_k] = u;
        end
      end
    end
    best = 0;
    for (int n = 0; n < 8; n++) begin
      m_pm[n]   = npm[n];
      m_hist[n] = nh[n];
      if (npm[n] < npm[best]) best = n;
    end
    has_out = (m_k >= 15);
    obit    = 1'b0;
    if (has_out) obit = m_hist[best][m_k - 15];
    m_k++;
  endtask

  always @(negedge clock) begin : compare
    exp_t e;
    if (!reset) begin
      check_output("oen_in_reset", sym.oen, 0);
      check_output("dx_in_reset", sym.Dx, 0);
      exp_dx = 1'b0;
    end else if (exp_q.size() > 0 && exp_q[0].at == cyc) begin
      e = exp_q.pop_front();
      check_output("oen_strobe", sym.oen, 1);
      check_output("dx_value", sym.Dx, e.val);
      exp_dx = e.val;
    end else begin
      check_output("oen_quiet", sym.oen, 0);
      check_output("dx_hold", sym.Dx, exp_dx);
    end
    if (reset && sym.oen === 1'b1) begin
      got_q.push_back(sym.Dx);
      oen_cycles.push_back(cyc);
    end
  end

  task automatic apply_reset();
    @(negedge clock);
    #2;
    reset      = 1'b0;
    sym.seqrdy = 1'b0;
    sym.Rx     = 2'b00;
    running    = 1'b0;
    exp_q.delete();
    #1;
    check_output("reset_oen", sym.oen, 0);
    check_output("reset_dx", sym.Dx, 0);
    repeat (3) @(negedge clock);
    #2;
    reset = 1'b1;
    model_reset();
    got_q.delete();
    oen_cycles.delete();
    start_cyc.delete();
  endtask

  // Called between a falling edge and the next rising edge; schedules the expected strobe
  // 18 cycles after the symbol's BM cycle when the window is already full.
  task automatic apply_stimulus(input logic [1:0] rx, input bit stall_after);
    logic has_out;
    logic obit;
    if (!running) begin
      sym.seqrdy = 1'b1;
      @(negedge clock);
      running = 1'b1;
    end
    sym.Rx = rx;
    start_cyc.push_back(cyc);
    model_step(rx, has_out, obit);
    if (has_out) exp_q.push_back('{at: cyc + 18, val: obit});
    if (stall_after) sym.seqrdy = 1'b0;
    repeat (has_out ? 19 : 3) @(negedge clock);
    if (stall_after) begin
      running = 1'b0;
      repeat (50) @(negedge clock);
    end
  endtask

  task automatic run_stream(input int nsym, input bit noisy, input int stall_a, input int stall_b);
    logic [2:0] es;
    logic [1:0] rx;
    es = 3'b000;
    for (int k = 0; k < nsym; k++) begin
      rx = encode(es, u_bits[k]);
      es = {u_bits[k], es[2:1]};
      if (noisy && (k % 8) == 3) rx = rx ^ 2'(2'b01 << $urandom_range(0, 1));
      apply_stimulus(rx, (k == stall_a) || (k == stall_b) || (k == nsym - 1));
    end
  endtask

  task automatic random_bits(input int n);
    u_bits.delete();
    for (int k = 0; k < n; k++) u_bits.push_back(1'($urandom_range(0, 1)));
  endtask

  task automatic check_delayed(input int n);
    check_output("decoded_count", got_q.size(), n);
    for (int i = 0; i < n && i < got_q.size(); i++) begin
      check_output("decoded_bit", got_q[i], u_bits[i]);
    end
  endtask

  initial begin : main
    int ones;
    sym.Rx     = 2'b00;
    sym.seqrdy = 1'b0;
    #1 reset = 1'b0;

    // All-zero stream: Dx stays 0, first strobe on the 19th cycle of symbol 15.
    apply_reset();
    u_bits.delete();
    for (int k = 0; k < 40; k++) u_bits.push_back(1'b0);
    run_stream(40, 1'b0, -1, -1);
    check_output("zeros_oen_count", got_q.size(), 25);
    ones = 0;
    foreach (got_q[i]) ones += int'(got_q[i]);
    check_output("zeros_dx_ones", ones, 0);
    if (oen_cycles.size() >= 2 && start_cyc.size() > 15) begin
      check_output("zeros_first_oen_offset", oen_cycles[0] - start_cyc[15], 18);
      check_output("zeros_oen_period", oen_cycles[1] - oen_cycles[0], 19);
    end

    // Impulse: Rx = 11,01,11,11,00,... decodes to 1,0,0 at symbols 15..17.
    apply_reset();
    u_bits.delete();
    u_bits.push_back(1'b1);
    for (int k = 1; k < 20; k++) u_bits.push_back(1'b0);
    check_output("impulse_rx1", encode(3'b100, 1'b0), 2'b01);
    run_stream(20, 1'b0, -1, -1);
    check_output("impulse_oen_count", got_q.size(), 5);
    if (got_q.size() >= 3) begin
      check_output("impulse_dx0", got_q[0], 1);
      check_output("impulse_dx1", got_q[1], 0);
      check_output("impulse_dx2", got_q[2], 0);
    end

    // Clean random stream equals the input delayed by 15 symbols.
    apply_reset();
    random_bits(45);
    run_stream(45, 1'b0, -1, -1);
    check_delayed(30);

    // One flipped code bit every 8 symbols, scored against the model each cycle.
    apply_reset();
    random_bits(45);
    run_stream(45, 1'b1, -1, -1);
    check_output("noisy_oen_count", got_q.size(), 30);

    // Stalls of 50 cycles during the fill phase and in steady state.
    apply_reset();
    random_bits(50);
    run_stream(50, 1'b0, 6, 25);
    check_delayed(35);

    // Reset during TRACE, then a clean restart including a fresh fill phase.
    apply_reset();
    random_bits(18);
    u_bits[2] = 1'b1;
    run_stream(18, 1'b0, -1, -1);
    check_output("abort_dx_before", sym.Dx, 1);
    sym.seqrdy = 1'b1;
    @(negedge clock);
    sym.Rx     = 2'b00;
    sym.seqrdy = 1'b0;
    repeat (8) @(negedge clock);
    apply_reset();
    random_bits(20);
    run_stream(20, 1'b0, -1, -1);
    check_delayed(5);
    if (oen_cycles.size() >= 1 && start_cyc.size() > 15) begin
      check_output("restart_first_oen_offset", oen_cycles[0] - start_cyc[15], 18);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
